// File: rtl/pwm_duty_ctrl_if.sv
// ---------------------------------------------------------------------------
// pwm_duty_ctrl_if
// Write port of the PWM duty-cycle controller (valid/ready plus error pulse).
//   wr_valid  master->slave  write request
//   wr_ready  slave->master  pending slot is free
//   wr_ch     master->slave  target channel index (CHW_G bits)
//   wr_duty   master->slave  target duty (DWIDTH_G bits)
//   wr_ramp   master->slave  1 = ramp to target, 0 = jump to target
//   wr_err    slave->master  one-cycle pulse: write to a non-existent channel
// ---------------------------------------------------------------------------
interface pwm_duty_ctrl_if #(
    parameter int CHW_G    = 2,
    parameter int DWIDTH_G = 8
);
    logic                wr_valid;
    logic                wr_ready;
    logic [CHW_G-1:0]    wr_ch;
    logic [DWIDTH_G-1:0] wr_duty;
    logic                wr_ramp;
    logic                wr_err;

    modport master (
        output wr_valid, wr_ch, wr_duty, wr_ramp,
        input  wr_ready, wr_err
    );

    modport slave (
        input  wr_valid, wr_ch, wr_duty, wr_ramp,
        output wr_ready, wr_err
    );
endinterface

// File: rtl/pwm_duty_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_duty_ctrl
// Duty-cycle controller for a bank of NCH_G pwm_gen channels. A single
// pending slot holds one duty update; it is committed only on a PWM period
// boundary so no channel sees a mid-period change. A committed update either
// jumps straight to its target or ramps toward it by STEP_G per period.
// Ports:
//   clk          system clock, all state on posedge
//   reset        asynchronous active-high, clears all state
//   enable       1 = process period ticks, 0 = freeze commits and ramps
//   period_tick  one-cycle pulse at the PWM period boundary
//   wr           write port (pwm_duty_ctrl_if.slave)
//   duty_out     per-channel duty, channel i at [i*DWIDTH_G +: DWIDTH_G]
//   busy         channel i is ramping
//   done         one-cycle pulse: channel i reached its target
// ---------------------------------------------------------------------------
module pwm_duty_ctrl #(
    parameter int DWIDTH_G = 8,
    parameter int NCH_G    = 4,
    parameter int CHW_G    = 2,
    parameter int STEP_G   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      period_tick,
    pwm_duty_ctrl_if.slave            wr,
    output logic [NCH_G*DWIDTH_G-1:0] duty_out,
    output logic [NCH_G-1:0]          busy,
    output logic [NCH_G-1:0]          done
);

    localparam logic signed [DWIDTH_G:0] STEP_S  = (DWIDTH_G+1)'(STEP_G);
    localparam logic [DWIDTH_G-1:0]      STEP_D  = DWIDTH_G'(STEP_G);
    localparam logic [CHW_G:0]           NCH_LIM = (CHW_G+1)'(NCH_G);

    // One ramp step of cur toward tgt. Returns {arrived, next_duty}.
    // The distance is formed in DWIDTH_G+1 signed bits, and a step is only
    // taken when the distance exceeds STEP_G, so the result never wraps.
    function automatic logic [DWIDTH_G:0] ramp_step(
        input logic [DWIDTH_G-1:0] cur,
        input logic [DWIDTH_G-1:0] tgt
    );
        logic signed [DWIDTH_G:0] diff;
        logic signed [DWIDTH_G:0] mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[DWIDTH_G] ? -diff : diff;
        if (mag <= STEP_S) begin
            return {1'b1, tgt};
        end else if (!diff[DWIDTH_G]) begin
            return {1'b0, cur + STEP_D};
        end else begin
            return {1'b0, cur - STEP_D};
        end
    endfunction

    logic                pend_vld;
    logic [CHW_G-1:0]    pend_ch;
    logic [DWIDTH_G-1:0] pend_duty;
    logic                pend_ramp;
    logic                wr_err_q;

    logic [DWIDTH_G-1:0] duty_q   [NCH_G];
    logic [DWIDTH_G-1:0] target_q [NCH_G];
    logic [NCH_G-1:0]    busy_q;
    logic [NCH_G-1:0]    done_q;

    logic                tick_en;
    logic                accept;
    logic                ch_ok;
    logic                commit;
    logic [NCH_G-1:0]    commit_sel;
    logic [DWIDTH_G-1:0] step_duty [NCH_G];
    logic [NCH_G-1:0]    step_arrive;

    // The ready flag depends only on registered state, never on wr_valid.
    assign wr.wr_ready = ~pend_vld;
    assign wr.wr_err   = wr_err_q;
    assign busy        = busy_q;
    assign done        = done_q;

    always_comb begin
        tick_en     = period_tick & enable;
        accept      = wr.wr_valid & ~pend_vld;
        ch_ok       = ({1'b0, wr.wr_ch} < NCH_LIM);
        commit      = tick_en & pend_vld;
        commit_sel  = '0;
        step_arrive = '0;
        duty_out    = '0;
        for (int i = 0; i < NCH_G; i++) begin
            logic [DWIDTH_G:0] r;
            r              = ramp_step(duty_q[i], target_q[i]);
            step_duty[i]   = r[DWIDTH_G-1:0];
            step_arrive[i] = r[DWIDTH_G];
            commit_sel[i]  = commit & (pend_ch == CHW_G'(i));
            duty_out[i*DWIDTH_G +: DWIDTH_G] = duty_q[i];
        end
    end

    // Pending slot: a write and a tick in the same cycle cannot commit
    // together because a commit needs the slot already full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld  <= 1'b0;
            pend_ch   <= '0;
            pend_duty <= '0;
            pend_ramp <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            wr_err_q <= accept & ~ch_ok;
            if (accept) begin
                pend_vld  <= ch_ok;
                pend_ch   <= wr.wr_ch;
                pend_duty <= wr.wr_duty;
                pend_ramp <= wr.wr_ramp;
            end else if (commit) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // Channel state: a commit to a channel takes priority over its ramp
    // step on the same tick; every other busy channel steps in parallel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            done_q <= '0;
            for (int i = 0; i < NCH_G; i++) begin
                duty_q[i]   <= '0;
                target_q[i] <= '0;
            end
        end else begin
            done_q <= '0;
            for (int i = 0; i < NCH_G; i++) begin
                if (commit_sel[i]) begin
                    target_q[i] <= pend_duty;
                    if (!pend_ramp) begin
                        duty_q[i] <= pend_duty;
                        busy_q[i] <= 1'b0;
                        done_q[i] <= 1'b1;
                    end else if (pend_duty != duty_q[i]) begin
                        busy_q[i] <= 1'b1;
                    end else begin
                        busy_q[i] <= 1'b0;
                        done_q[i] <= 1'b1;
                    end
                end else if (tick_en && busy_q[i]) begin
                    duty_q[i] <= step_duty[i];
                    if (step_arrive[i]) begin
                        busy_q[i] <= 1'b0;
                        done_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
